// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle PC / instruction-fetch controller.
// Walks FETCH -> DECODE -> RESOLVE -> UPDATE. It owns the PC and computes every
// next-PC source internally: pc+4, branch target, jump target and jr target.
// Optional feature macro: ALIGN_CHK_EN. When it is defined, a misaligned jr
// target raises exc and redirects the PC to EXC_VECTOR. When it is undefined,
// the low two bits of the jr target are cleared.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic [31:0] instr,
    input  logic        ctl_valid,
    input  logic        ctl_jump,
    input  logic        ctl_link,
    input  logic        ctl_jr,
    input  logic        ctl_branch,
    input  logic        br_taken,
    input  logic [31:0] rs_data,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        ir_write,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        exc,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_RESOLVE = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] link_data_q, link_data_d;
    logic        ir_write_q, ir_write_d;
    logic        mem_rd_q, mem_rd_d;
    logic        link_we_q, link_we_d;
    logic        exc_q, exc_d;

    // Sign-extended, word-scaled branch offset added to pc+4 (wraps modulo 2^32)
    function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [15:0] imm);
        branch_target = base + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Next-state, next-PC selection and strobe generation
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_plus4_d  = pc_plus4_q;
        ir_d        = ir_q;
        next_pc_d   = next_pc_q;
        link_data_d = link_data_q;
        ir_write_d  = 1'b0;
        link_we_d   = 1'b0;
        exc_d       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d       = instr;
                    ir_write_d = 1'b1;
                    pc_plus4_d = pc_q + 32'd4;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (ctl_valid) begin
                    link_we_d   = ctl_link;
                    link_data_d = pc_plus4_q;
                    if (ctl_jr) begin
`ifdef ALIGN_CHK_EN
                        if (rs_data[1:0] != 2'b00) begin
                            next_pc_d = EXC_VECTOR;
                            exc_d     = 1'b1;
                            link_we_d = 1'b0;
                        end else begin
                            next_pc_d = rs_data;
                        end
`else
                        next_pc_d = {rs_data[31:2], 2'b00};
`endif
                    end else if (ctl_jump) begin
                        next_pc_d = {pc_plus4_q[31:28], ir_q[25:0], 2'b00};
                    end else if (ctl_branch && br_taken) begin
                        next_pc_d = branch_target(pc_plus4_q, ir_q[15:0]);
                    end else begin
                        next_pc_d = pc_plus4_q;
                    end
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_RESOLVE;
                end
            end
            S_UPDATE: begin
                pc_d    = next_pc_q;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // The fetch request is registered so that it is high for the whole FETCH stay
        mem_rd_d = (state_d == S_FETCH);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            pc_plus4_q  <= RESET_PC + 32'd4;
            ir_q        <= 32'h0000_0000;
            next_pc_q   <= RESET_PC;
            link_data_q <= 32'h0000_0000;
            ir_write_q  <= 1'b0;
            mem_rd_q    <= 1'b1;
            link_we_q   <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_plus4_d;
            ir_q        <= ir_d;
            next_pc_q   <= next_pc_d;
            link_data_q <= link_data_d;
            ir_write_q  <= ir_write_d;
            mem_rd_q    <= mem_rd_d;
            link_we_q   <= link_we_d;
            exc_q       <= exc_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = pc_q;
    assign ir_write  = ir_write_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_q;
    assign link_we   = link_we_q;
    assign link_data = link_data_q;
    assign exc       = exc_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// It covers reset, j, jal, branch taken and not taken, link without jump, memory
// wait states, reset mid-RESOLVE, jr alignment handling (follows ALIGN_CHK_EN)
// and pc wrap-around.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, mem_ready, ctl_valid, ctl_jump, ctl_link, ctl_jr, ctl_branch, br_taken;
    logic [31:0] instr, rs_data;
    logic        mem_rd, ir_write, link_we, exc;
    logic [31:0] mem_addr, ir, pc, pc_plus4, link_data;
    logic [1:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic        lwe, ex;
    logic [31:0] ldat;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .instr(instr),
        .ctl_valid(ctl_valid), .ctl_jump(ctl_jump), .ctl_link(ctl_link),
        .ctl_jr(ctl_jr), .ctl_branch(ctl_branch), .br_taken(br_taken),
        .rs_data(rs_data), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .ir_write(ir_write), .ir(ir), .pc(pc), .pc_plus4(pc_plus4),
        .link_we(link_we), .link_data(link_data), .exc(exc), .state_o(state_o)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: FETCH (zero wait) -> DECODE -> RESOLVE -> UPDATE -> FETCH
    task automatic run_instr(input string tag, input logic [31:0] iw, input logic j, input logic l,
                             input logic jr_i, input logic br, input logic tk, input logic [31:0] rs,
                             output logic lwe_o, output logic [31:0] ldata_o, output logic ex_o);
        check_eq({tag, "_start_fetch"}, {30'd0, state_o}, 32'd0);
        instr = iw; mem_ready = 1'b1; ctl_valid = 1'b0;
        ctl_jump = j; ctl_link = l; ctl_jr = jr_i; ctl_branch = br; br_taken = tk; rs_data = rs;
        step();
        mem_ready = 1'b0;
        check_eq({tag, "_ir_write"}, {31'd0, ir_write}, 32'd1);
        check_eq({tag, "_ir"}, ir, iw);
        ctl_valid = 1'b1;
        step();
        step();
        check_eq({tag, "_in_update"}, {30'd0, state_o}, 32'd3);
        lwe_o = link_we; ldata_o = link_data; ex_o = exc;
        ctl_valid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; ctl_valid = 1'b0; ctl_jump = 1'b0; ctl_link = 1'b0;
        ctl_jr = 1'b0; ctl_branch = 1'b0; br_taken = 1'b0; instr = 32'h0; rs_data = 32'h0;

        // Reset held two cycles
        step(); step();
        check_eq("rst_pc", pc, 32'h0000_0000);
        check_eq("rst_pc4", pc_plus4, 32'h0000_0004);
        check_eq("rst_ir", ir, 32'h0000_0000);
        check_eq("rst_state", {30'd0, state_o}, 32'd0);
        check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd1);
        check_eq("rst_strobes", {29'd0, ir_write, link_we, exc}, 32'd0);
        reset = 1'b1;
        step();
        check_eq("post_rst_state", {30'd0, state_o}, 32'd0);
        check_eq("post_rst_addr", mem_addr, 32'h0000_0000);

        // Move the PC to 0xE000_0000 with jr, then j idx 0x021EAAA
        run_instr("jr_e", 32'h03E0_0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hE000_0000, lwe, ldat, ex);
        check_eq("jr_e_pc", pc, 32'hE000_0000);
        run_instr("j", 32'h0821_EAAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, lwe, ldat, ex);
        check_eq("j_pc", pc, 32'hE087_AAA8);
        check_eq("j_link_we", {31'd0, lwe}, 32'd0);

        // jal idx 300 from 0x7000_0000
        run_instr("jr_7", 32'h03E0_0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7000_0000, lwe, ldat, ex);
        run_instr("jal", 32'h0C00_012C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, lwe, ldat, ex);
        check_eq("jal_pc", pc, 32'h7000_04B0);
        check_eq("jal_link_we", {31'd0, lwe}, 32'd1);
        check_eq("jal_link_data", ldat, 32'h7000_0004);
        check_eq("jal_link_we_pulse", {31'd0, link_we}, 32'd0);

        // beq imm=0xFFFF at 0x100: taken loops to itself, not taken falls through
        run_instr("jr_100", 32'h03E0_0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, lwe, ldat, ex);
        run_instr("beq_t", 32'h1000_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, lwe, ldat, ex);
        check_eq("beq_taken_pc", pc, 32'h0000_0100);
        run_instr("beq_nt", 32'h1000_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, lwe, ldat, ex);
        check_eq("beq_not_taken_pc", pc, 32'h0000_0104);

        // ctl_link without ctl_jump still links and falls through
        run_instr("link_only", 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, lwe, ldat, ex);
        check_eq("link_only_pc", pc, 32'h0000_0108);
        check_eq("link_only_we", {31'd0, lwe}, 32'd1);
        check_eq("link_only_data", ldat, 32'h0000_0108);

        // Memory wait states: request held, no ir_write, ctl_valid ignored in FETCH
        ctl_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("wait_mem_rd", {31'd0, mem_rd}, 32'd1);
            check_eq("wait_ir_write", {31'd0, ir_write}, 32'd0);
            check_eq("wait_state", {30'd0, state_o}, 32'd0);
        end
        ctl_valid = 1'b0;
        instr = 32'h1234_5678; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("wait_ir", ir, 32'h1234_5678);
        step();
        step();
        check_eq("resolve_hold", {30'd0, state_o}, 32'd2);
        // Reset mid-RESOLVE
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("mid_rst_pc", pc, 32'h0000_0000);
        check_eq("mid_rst_state", {30'd0, state_o}, 32'd0);
        check_eq("mid_rst_ir", ir, 32'h0000_0000);
        check_eq("mid_rst_pc4", pc_plus4, 32'h0000_0004);

        // Misaligned jr target 0x203
        run_instr("jr_mis", 32'h03E0_0008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0203, lwe, ldat, ex);
`ifdef ALIGN_CHK_EN
        check_eq("jr_mis_pc", pc, 32'h0000_00FC);
        check_eq("jr_mis_exc", {31'd0, ex}, 32'd1);
        check_eq("jr_mis_link_we", {31'd0, lwe}, 32'd0);
`else
        check_eq("jr_mis_pc", pc, 32'h0000_0200);
        check_eq("jr_mis_exc", {31'd0, ex}, 32'd0);
        check_eq("jr_mis_link_we", {31'd0, lwe}, 32'd1);
`endif

        // PC wrap: 0xFFFF_FFFC + 4 -> 0
        run_instr("jr_top", 32'h03E0_0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, lwe, ldat, ex);
        check_eq("jr_top_pc", pc, 32'hFFFF_FFFC);
        run_instr("wrap", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, lwe, ldat, ex);
        check_eq("wrap_pc", pc, 32'h0000_0000);
        check_eq("wrap_exc", {31'd0, ex}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
